// File: rtl/orv64_param_pkg.sv
// Core-wide default parameters for the orv64 pipeline.
package orv64_param_pkg;
    localparam int ORV64_XLEN   = 64;
    localparam int ORV64_N_IREG = 32;
endpackage

// File: rtl/orv64_typedef_pkg.sv
// Shared integer register file request types built on the default core parameters.
package orv64_typedef_pkg;
    import orv64_param_pkg::*;

    localparam int ORV64_IREG_AW = $clog2(ORV64_N_IREG);

    typedef logic [ORV64_IREG_AW-1:0] orv64_ireg_addr_t;

    typedef struct packed {
        logic             re;
        orv64_ireg_addr_t addr;
    } orv64_irf_rd_req_t;

    typedef struct packed {
        logic                  we;
        orv64_ireg_addr_t      addr;
        logic [ORV64_XLEN-1:0] data;
    } orv64_irf_wr_req_t;
endpackage

// File: rtl/orv64_int_regfile_mp_if.sv
// Bundle of read, issue, write and flush signals between the pipeline and the integer register file.
interface orv64_int_regfile_mp_if
    import orv64_param_pkg::*;
#(
    parameter int XLEN  = ORV64_XLEN,
    parameter int N_REG = ORV64_N_IREG,
    parameter int N_RD  = 2,
    parameter int N_WR  = 1
) ();
    localparam int AW = $clog2(N_REG);

    logic [N_RD-1:0]            rd_re;
    logic [N_RD-1:0][AW-1:0]    rd_addr;
    logic [N_RD-1:0][XLEN-1:0]  rd_data;
    logic [N_RD-1:0]            rd_busy;
    logic                       iss_vld;
    logic [AW-1:0]              iss_addr;
    logic [N_WR-1:0]            wr_we;
    logic [N_WR-1:0][AW-1:0]    wr_addr;
    logic [N_WR-1:0][XLEN-1:0]  wr_data;
    logic                       flush;
    logic [AW:0]                busy_cnt;

    modport master (
        output rd_re, rd_addr, iss_vld, iss_addr, wr_we, wr_addr, wr_data, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_re, rd_addr, iss_vld, iss_addr, wr_we, wr_addr, wr_data, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/orv64_irf_scoreboard.sv
// Busy scoreboard for in-flight integer register writes: set on issue, clear on write, wipe on flush.
module orv64_irf_scoreboard #(
    parameter int N_REG = 32,
    parameter int N_WR  = 1,
    parameter int AW    = $clog2(N_REG)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    iss_vld_i,
    input  logic [AW-1:0]           iss_addr_i,
    input  logic [N_WR-1:0]         wr_we_i,
    input  logic [N_WR-1:0][AW-1:0] wr_addr_i,
    input  logic                    flush_i,
    output logic [N_REG-1:0]        busy_nxt_o,
    output logic [AW:0]             busy_cnt_o
);
    logic [N_REG-1:0] busy_q;
    logic [N_REG-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    function automatic logic [AW:0] popcount(input logic [N_REG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int k = 0; k < N_REG; k++) begin
            c = c + {{AW{1'b0}}, v[k]};
        end
        return c;
    endfunction

    // Next busy vector: clears first, then a new producer's set, with flush overriding both.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < N_WR; i++) begin
            busy_d[wr_addr_i[i]] = busy_d[wr_addr_i[i]] & ~wr_we_i[i];
        end
        busy_d[iss_addr_i] = busy_d[iss_addr_i] | iss_vld_i;
        busy_d[0] = 1'b0;
        busy_d = flush_i ? '0 : busy_d;
    end

    // Count is derived from the same next vector so it always matches the registered busy bits.
    always_comb begin
        cnt_d = popcount(busy_d);
    end

    // Busy and count state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_nxt_o = busy_d;
    assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/orv64_int_regfile_mp.sv
// Multi-port integer register file with registered reads, write-to-read bypass and a busy scoreboard.
module orv64_int_regfile_mp
    import orv64_param_pkg::*;
#(
    parameter int XLEN  = ORV64_XLEN,
    parameter int N_REG = ORV64_N_IREG,
    parameter int N_RD  = 2,
    parameter int N_WR  = 1
) (
    input logic                   clk_i,
    input logic                   rst_i,
    orv64_int_regfile_mp_if.slave rf_if
);
    localparam int AW = $clog2(N_REG);

    logic [XLEN-1:0]           regs_q [N_REG];
    logic [XLEN-1:0]           regs_d [N_REG];
    logic [N_RD-1:0][XLEN-1:0] rd_data_q;
    logic [N_RD-1:0][XLEN-1:0] rd_data_d;
    logic [N_RD-1:0]           rd_busy_q;
    logic [N_RD-1:0]           rd_busy_d;
    logic [N_REG-1:0]          busy_nxt_s;
    logic [AW:0]               busy_cnt_s;

    orv64_irf_scoreboard #(
        .N_REG (N_REG),
        .N_WR  (N_WR),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .iss_vld_i  (rf_if.iss_vld),
        .iss_addr_i (rf_if.iss_addr),
        .wr_we_i    (rf_if.wr_we),
        .wr_addr_i  (rf_if.wr_addr),
        .flush_i    (rf_if.flush),
        .busy_nxt_o (busy_nxt_s),
        .busy_cnt_o (busy_cnt_s)
    );

    // Post-write register image; later ports overwrite earlier ones, and x0 is forced back to zero.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < N_WR; i++) begin
            regs_d[rf_if.wr_addr[i]] = rf_if.wr_we[i] ? rf_if.wr_data[i] : regs_d[rf_if.wr_addr[i]];
        end
        regs_d[0] = '0;
    end

    // Reads sample the post-write image, which is what gives same-cycle bypass for free.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < N_RD; p++) begin
            rd_data_d[p] = rf_if.rd_re[p] ? regs_d[rf_if.rd_addr[p]]     : rd_data_q[p];
            rd_busy_d[p] = rf_if.rd_re[p] ? busy_nxt_s[rf_if.rd_addr[p]] : rd_busy_q[p];
        end
    end

    // Storage and read-port registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_REG; k++) begin
                regs_q[k] <= '0;
            end
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rf_if.rd_data  = rd_data_q;
    assign rf_if.rd_busy  = rd_busy_q;
    assign rf_if.busy_cnt = busy_cnt_s;

    // ABI-named views of the storage array for waveform debug; nothing in the datapath uses them.
    logic [XLEN-1:0] abi_ra;
    logic [XLEN-1:0] abi_sp;
    logic [XLEN-1:0] abi_a0;
    logic [XLEN-1:0] abi_a1;
    assign abi_ra = regs_q[1];
    assign abi_sp = regs_q[2];
    assign abi_a0 = regs_q[10];
    assign abi_a1 = regs_q[11];
endmodule

// File: tb/tb_orv64_int_regfile_mp.sv
// Directed vector table plus randomized traffic checked against an array-based register file model.
module tb_orv64_int_regfile_mp;
    import orv64_typedef_pkg::*;

    localparam int XLEN  = 64;
    localparam int N_REG = 32;
    localparam int N_RD  = 2;
    localparam int N_WR  = 2;
    localparam logic [63:0] Z = 64'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    orv64_int_regfile_mp_if #(.XLEN(XLEN), .N_REG(N_REG), .N_RD(N_RD), .N_WR(N_WR)) rf_if ();

    orv64_int_regfile_mp #(.XLEN(XLEN), .N_REG(N_REG), .N_RD(N_RD), .N_WR(N_WR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rf_if (rf_if)
    );

    typedef struct {
        logic             rst;
        logic             flush;
        logic             iss;
        orv64_ireg_addr_t ia;
        logic [1:0]       re;
        orv64_ireg_addr_t ra0;
        orv64_ireg_addr_t ra1;
        logic [1:0]       we;
        orv64_ireg_addr_t wa0;
        orv64_ireg_addr_t wa1;
        logic [63:0]      wd0;
        logic [63:0]      wd1;
    } in_t;

    typedef struct {
        in_t         i;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  b;
        logic [5:0]  cnt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural registers, busy flags, and what each read port last captured.
    logic [63:0] m_reg  [32];
    logic        m_busy [32];
    logic [63:0] m_rd   [2];
    logic [1:0]  m_rb;

    function automatic vec_t row(input logic r, input logic fl, input logic is, input orv64_ireg_addr_t ia,
                                 input logic [1:0] re, input orv64_ireg_addr_t a0, input orv64_ireg_addr_t a1,
                                 input logic [1:0] we, input orv64_ireg_addr_t w0, input orv64_ireg_addr_t w1,
                                 input logic [63:0] dd0, input logic [63:0] dd1,
                                 input logic [63:0] e0, input logic [63:0] e1,
                                 input logic [1:0] eb, input logic [5:0] ec);
        vec_t v;
        v.i.rst = r;  v.i.flush = fl; v.i.iss = is; v.i.ia = ia;
        v.i.re = re;  v.i.ra0 = a0;   v.i.ra1 = a1;
        v.i.we = we;  v.i.wa0 = w0;   v.i.wa1 = w1; v.i.wd0 = dd0; v.i.wd1 = dd1;
        v.d0 = e0; v.d1 = e1; v.b = eb; v.cnt = ec;
        return v;
    endfunction

    function automatic logic [5:0] m_count();
        logic [5:0] c;
        c = 6'd0;
        for (int k = 0; k < 32; k++) begin
            if (m_busy[k]) c = c + 6'd1;
        end
        return c;
    endfunction

    // Apply one edge of the architectural rules: writes land, busy updates, then enabled ports sample.
    task automatic model_step(input in_t x);
        if (x.rst) begin
            for (int k = 0; k < 32; k++) begin
                m_reg[k]  = 64'h0;
                m_busy[k] = 1'b0;
            end
            m_rd[0] = 64'h0;
            m_rd[1] = 64'h0;
            m_rb    = 2'b00;
        end else begin
            if (x.we[0] && x.wa0 != 5'd0) m_reg[x.wa0] = x.wd0;
            if (x.we[1] && x.wa1 != 5'd0) m_reg[x.wa1] = x.wd1;
            if (x.we[0]) m_busy[x.wa0] = 1'b0;
            if (x.we[1]) m_busy[x.wa1] = 1'b0;
            if (x.iss && x.ia != 5'd0) m_busy[x.ia] = 1'b1;
            if (x.flush) begin
                for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
            end
            if (x.re[0]) begin
                m_rd[0] = m_reg[x.ra0];
                m_rb[0] = m_busy[x.ra0];
            end
            if (x.re[1]) begin
                m_rd[1] = m_reg[x.ra1];
                m_rb[1] = m_busy[x.ra1];
            end
        end
    endtask

    task automatic apply(input in_t x);
        rst            = x.rst;
        rf_if.flush    = x.flush;
        rf_if.iss_vld  = x.iss;
        rf_if.iss_addr = x.ia;
        rf_if.rd_re    = x.re;
        rf_if.rd_addr[0] = x.ra0;
        rf_if.rd_addr[1] = x.ra1;
        rf_if.wr_we    = x.we;
        rf_if.wr_addr[0] = x.wa0;
        rf_if.wr_addr[1] = x.wa1;
        rf_if.wr_data[0] = x.wd0;
        rf_if.wr_data[1] = x.wd1;
        @(posedge clk);
        model_step(x);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    vec_t tbl [28];
    in_t  rx;

    initial begin
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = 64'h0;
            m_busy[k] = 1'b0;
        end
        m_rd[0] = 64'h0;
        m_rd[1] = 64'h0;
        m_rb    = 2'b00;

        //             rst   fl    iss   ia      re     a0      a1      we     w0      w1      wd0                   wd1       d0        d1        b      cnt
        tbl[0]  = row(1'b1, 1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd0);
        tbl[1]  = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  2'b01, 5'd5,  5'd0,  64'h1234,             Z,        Z,        Z,        2'b00, 6'd0);
        tbl[2]  = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b01, 5'd5,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        64'h1234, Z,        2'b00, 6'd0);
        tbl[3]  = row(1'b1, 1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd0);
        tbl[4]  = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b01, 5'd5,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd0);
        tbl[5]  = row(1'b0, 1'b0, 1'b1, 5'd0,  2'b00, 5'd0,  5'd0,  2'b01, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, Z,      Z,        Z,        2'b00, 6'd0);
        tbl[6]  = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b11, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd0);
        tbl[7]  = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b01, 5'd7,  5'd0,  2'b11, 5'd7,  5'd7,  64'hAA,               64'hBB,   64'hBB,   Z,        2'b00, 6'd0);
        tbl[8]  = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b01, 5'd7,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        64'hBB,   Z,        2'b00, 6'd0);
        tbl[9]  = row(1'b0, 1'b0, 1'b1, 5'd10, 2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        64'hBB,   Z,        2'b00, 6'd1);
        tbl[10] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b10, 5'd0,  5'd10, 2'b00, 5'd0,  5'd0,  Z,                    Z,        64'hBB,   Z,        2'b10, 6'd1);
        tbl[11] = row(1'b0, 1'b0, 1'b1, 5'd10, 2'b10, 5'd0,  5'd10, 2'b01, 5'd10, 5'd0,  64'h10,               Z,        64'hBB,   64'h10,   2'b10, 6'd1);
        tbl[12] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b01, 5'd10, 5'd0,  2'b10, 5'd0,  5'd10, Z,                    64'h11,   64'h11,   64'h10,   2'b10, 6'd0);
        tbl[13] = row(1'b0, 1'b0, 1'b1, 5'd1,  2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        64'h11,   64'h10,   2'b10, 6'd1);
        tbl[14] = row(1'b0, 1'b0, 1'b1, 5'd2,  2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        64'h11,   64'h10,   2'b10, 6'd2);
        tbl[15] = row(1'b0, 1'b0, 1'b1, 5'd3,  2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        64'h11,   64'h10,   2'b10, 6'd3);
        tbl[16] = row(1'b0, 1'b1, 1'b1, 5'd4,  2'b11, 5'd3,  5'd4,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd0);
        tbl[17] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b11, 5'd1,  5'd4,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd0);
        tbl[18] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  2'b01, 5'd3,  5'd0,  64'h55,               Z,        Z,        Z,        2'b00, 6'd0);
        tbl[19] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b10, 5'd0,  5'd3,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        64'h55,   2'b00, 6'd0);
        tbl[20] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  5'd3,  2'b10, 5'd0,  5'd3,  Z,                    64'h66,   Z,        64'h55,   2'b00, 6'd0);
        tbl[21] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        64'h55,   2'b00, 6'd0);
        tbl[22] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b10, 5'd0,  5'd3,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        64'h66,   2'b00, 6'd0);
        tbl[23] = row(1'b1, 1'b0, 1'b1, 5'd9,  2'b01, 5'd9,  5'd0,  2'b01, 5'd9,  5'd0,  64'h99,               Z,        Z,        Z,        2'b00, 6'd0);
        tbl[24] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b01, 5'd9,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd0);
        tbl[25] = row(1'b0, 1'b0, 1'b1, 5'd12, 2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  Z,                    Z,        Z,        Z,        2'b00, 6'd1);
        tbl[26] = row(1'b0, 1'b0, 1'b0, 5'd0,  2'b01, 5'd12, 5'd0,  2'b01, 5'd12, 5'd0,  64'h12,               Z,        64'h12,   Z,        2'b00, 6'd0);
        tbl[27] = row(1'b0, 1'b0, 1'b1, 5'd13, 2'b10, 5'd0,  5'd13, 2'b00, 5'd0,  5'd0,  Z,                    Z,        64'h12,   Z,        2'b10, 6'd1);

        for (int n = 0; n < 28; n++) begin
            apply(tbl[n].i);
            chk($sformatf("vec%0d_rd_data0", n), rf_if.rd_data[0], tbl[n].d0);
            chk($sformatf("vec%0d_rd_data1", n), rf_if.rd_data[1], tbl[n].d1);
            chk($sformatf("vec%0d_rd_busy", n), 64'(rf_if.rd_busy), 64'(tbl[n].b));
            chk($sformatf("vec%0d_busy_cnt", n), 64'(rf_if.busy_cnt), 64'(tbl[n].cnt));
        end

        // Random traffic; narrow address range half the time so ports collide often.
        for (int n = 0; n < 400; n++) begin
            logic narrow;
            narrow   = 1'($urandom_range(0, 1));
            rx.rst   = ($urandom_range(0, 63) == 0);
            rx.flush = ($urandom_range(0, 15) == 0);
            rx.iss   = 1'($urandom_range(0, 1));
            rx.re    = 2'($urandom_range(0, 3));
            rx.we    = 2'($urandom_range(0, 3));
            rx.ia    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rx.ra0   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rx.ra1   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rx.wa0   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rx.wa1   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rx.wd0   = {$urandom, $urandom};
            rx.wd1   = {$urandom, $urandom};
            apply(rx);
            chk($sformatf("rnd%0d_rd_data0", n), rf_if.rd_data[0], m_rd[0]);
            chk($sformatf("rnd%0d_rd_data1", n), rf_if.rd_data[1], m_rd[1]);
            chk($sformatf("rnd%0d_rd_busy", n), 64'(rf_if.rd_busy), 64'(m_rb));
            chk($sformatf("rnd%0d_busy_cnt", n), 64'(rf_if.busy_cnt), 64'(m_count()));
        end

        // ABI debug aliases track the storage array.
        rx = row(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 5'd1, 5'd2,
                 64'hA1A1, 64'hA2A2, Z, Z, 2'b00, 6'd0).i;
        apply(rx);
        rx = row(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 5'd10, 5'd11,
                 64'hB0B0, 64'hB1B1, Z, Z, 2'b00, 6'd0).i;
        apply(rx);
        chk("abi_ra", dut.abi_ra, 64'hA1A1);
        chk("abi_sp", dut.abi_sp, 64'hA2A2);
        chk("abi_a0", dut.abi_a0, 64'hB0B0);
        chk("abi_a1", dut.abi_a1, 64'hB1B1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
